hazard_scoreboard: RTL and testbench

Parametrised stall/flush controller for the pipelined CPU, the next generation of the stage-compare hazard detector. It tracks every pending register write with a per-register countdown scoreboard, so producers of any latency up to MAX_LAT are handled, and it supports configurable forwarding slack and multi-cycle redirect flushes. It sits beside the ID stage and drives PC write-enable, IF/ID write-enable, the control-bubble mux and the IF/ID flush.

---
 rtl/hazard_pkg.sv | 17 +
 rtl/reg_scoreboard.sv | 51 +++++
 rtl/hazard_scoreboard.sv | 148 ++++++++++++++
 tb/tb_hazard_scoreboard.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types and output-vector encodings for the hazard scoreboard.
// Output vectors are ordered {pc_write, if_id_write, control, if_id_flush}.
package hazard_pkg;

    typedef enum logic {
        RUN      = 1'b0,
        REDIRECT = 1'b1
    } state_t;

    localparam logic [3:0] OUT_STALL    = 4'b0000;
    localparam logic [3:0] OUT_REDIRECT = 4'b1011;
    localparam logic [3:0] OUT_NORMAL   = 4'b1110;
    localparam logic [3:0] OUT_RESET    = 4'b0001;

    localparam int MAX_LAT_DEF = 7;

endpackage

// File: rtl/reg_scoreboard.sv
// Per-register countdown of cycles until a pending write reaches the register file,
// with strict (any pending) and slack (beyond forwarding reach) busy results for two sources.
module reg_scoreboard #(
    parameter int NUM_REGS  = 32,
    parameter int REG_W     = $clog2(NUM_REGS),
    parameter int MAX_LAT   = 7,
    parameter int LAT_W     = $clog2(MAX_LAT + 1),
    parameter int FWD_SLACK = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             issue,
    input  logic [REG_W-1:0] issue_rd,
    input  logic [LAT_W-1:0] issue_lat,
    input  logic [REG_W-1:0] rs,
    input  logic [REG_W-1:0] rt,
    output logic             rs_busy_strict,
    output logic             rs_busy_slack,
    output logic             rt_busy_strict,
    output logic             rt_busy_slack
);

    logic [LAT_W-1:0] cnt [NUM_REGS];
    logic [LAT_W-1:0] lat_c;

    assign lat_c = (int'(issue_lat) > MAX_LAT) ? LAT_W'(MAX_LAT) : issue_lat;

    // A fresh issue replaces whatever the register was counting (youngest writer wins).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                cnt[r] <= '0;
            end
        end else begin
            cnt[0] <= '0;
            for (int r = 1; r < NUM_REGS; r++) begin
                if (issue && (int'(issue_rd) == r)) begin
                    cnt[r] <= lat_c;
                end else if (cnt[r] != '0) begin
                    cnt[r] <= cnt[r] - 1'b1;
                end
            end
        end
    end

    assign rs_busy_strict = (cnt[rs] != '0);
    assign rt_busy_strict = (cnt[rt] != '0);
    assign rs_busy_slack  = (int'(cnt[rs]) > FWD_SLACK);
    assign rt_busy_slack  = (int'(cnt[rt]) > FWD_SLACK);

endmodule

// File: rtl/hazard_scoreboard.sv
// Stall/flush controller beside ID: scoreboard-based data hazards, control-source hazards,
// multi-cycle redirect flushes, a saturating stall counter and a sticky stall watchdog.
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int NUM_REGS    = 32,
    parameter int REG_W       = $clog2(NUM_REGS),
    parameter int MAX_LAT     = MAX_LAT_DEF,
    parameter int LAT_W       = $clog2(MAX_LAT + 1),
    parameter int FWD_SLACK   = 0,
    parameter int FLUSH_DEPTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_uses_rs,
    input  logic             id_uses_rt,
    input  logic             id_reg_write,
    input  logic [REG_W-1:0] id_rd,
    input  logic [LAT_W-1:0] id_latency,
    input  logic             jump,
    input  logic             jump_reg,
    input  logic             branch,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             control,
    output logic             if_id_flush,
    output logic [31:0]      stall_count,
    output logic             error
);

    localparam int FL_W = 3;
    localparam int SR_W = $clog2(MAX_LAT + 3) + 1;

    state_t          state, state_next;
    logic [FL_W-1:0] flush_cnt, flush_next;
    logic [SR_W-1:0] stall_run;
    logic [3:0]      outv;
    logic            stall, issue_ok, issue;
    logic            rs_busy_strict, rs_busy_slack, rt_busy_strict, rt_busy_slack;
    logic            data_hz, ctl_hz, redirect_req;

    assign issue = issue_ok & id_reg_write & (id_rd != '0) & (id_latency != '0);

    reg_scoreboard #(
        .NUM_REGS  (NUM_REGS),
        .REG_W     (REG_W),
        .MAX_LAT   (MAX_LAT),
        .LAT_W     (LAT_W),
        .FWD_SLACK (FWD_SLACK)
    ) u_sb (
        .clk            (clk),
        .rst_n          (rst_n),
        .issue          (issue),
        .issue_rd       (id_rd),
        .issue_lat      (id_latency),
        .rs             (id_rs),
        .rt             (id_rt),
        .rs_busy_strict (rs_busy_strict),
        .rs_busy_slack  (rs_busy_slack),
        .rt_busy_strict (rt_busy_strict),
        .rt_busy_slack  (rt_busy_slack)
    );

    // Branch/jump operands are read in ID itself, so forwarding slack cannot help them.
    assign data_hz      = (id_uses_rs & rs_busy_slack) | (id_uses_rt & rt_busy_slack);
    assign ctl_hz       = (jump_reg & rs_busy_strict) | (branch & (rs_busy_strict | rt_busy_strict));
    assign redirect_req = jump | jump_reg | branch;

    always_comb begin
        state_next = state;
        flush_next = flush_cnt;
        outv       = OUT_NORMAL;
        stall      = 1'b0;
        issue_ok   = 1'b0;
        case (state)
            RUN: begin
                if (id_valid) begin
                    if (data_hz | ctl_hz) begin
                        outv  = OUT_STALL;
                        stall = 1'b1;
                    end else begin
                        issue_ok = 1'b1;
                        if (redirect_req) begin
                            outv = OUT_REDIRECT;
                            if (FLUSH_DEPTH > 1) begin
                                state_next = REDIRECT;
                                flush_next = FL_W'(FLUSH_DEPTH - 1);
                            end
                        end
                    end
                end
            end
            REDIRECT: begin
                outv = OUT_REDIRECT;
                if (flush_cnt <= FL_W'(1)) begin
                    state_next = RUN;
                    flush_next = '0;
                end else begin
                    flush_next = flush_cnt - 1'b1;
                end
            end
            default: state_next = RUN;
        endcase
        if (!rst_n) begin
            outv  = OUT_RESET;
            stall = 1'b0;
        end
    end

    assign {pc_write, if_id_write, control, if_id_flush} = outv;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= RUN;
            flush_cnt <= '0;
        end else begin
            state     <= state_next;
            flush_cnt <= flush_next;
        end
    end

    // Watchdog trips on the stall that makes the consecutive run exceed MAX_LAT+1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_run   <= '0;
            stall_count <= '0;
            error       <= 1'b0;
        end else begin
            if (stall) begin
                if (stall_run != '1) begin
                    stall_run <= stall_run + 1'b1;
                end
                if (int'(stall_run) >= MAX_LAT + 1) begin
                    error <= 1'b1;
                end
            end else begin
                stall_run <= '0;
            end
            if (!pc_write && (stall_count != '1)) begin
                stall_count <= stall_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Randomized scoreboard bench: three controller configurations share one stimulus stream and
// are checked each cycle against a ready-time reference model.
module tb_hazard_scoreboard;

    localparam int MAXL = 7;

    logic       clk;
    logic       rst_n;
    logic       id_valid, id_uses_rs, id_uses_rt, id_reg_write, jump, jump_reg, branch;
    logic [4:0] id_rs, id_rt, id_rd;
    logic [2:0] id_latency;

    wire  [3:0]  dout [3];
    wire  [31:0] scnt [3];
    wire  [2:0]  derr;

    typedef struct packed {
        logic [2:0][3:0]  outv;
        logic [2:0][31:0] sc;
        logic [2:0]       err;
    } exp_t;

    exp_t   expq[$];
    exp_t   me;
    int     checks = 0;
    int     errors = 0;

    longint ready_at [3][32];
    int     flush_left [3];
    longint scm [3];
    bit     errm [3];
    int     runm [3];
    longint ncyc = 0;

    hazard_scoreboard #(.FWD_SLACK(0), .FLUSH_DEPTH(1)) dut0 (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_reg_write(id_reg_write),
        .id_rd(id_rd), .id_latency(id_latency), .jump(jump), .jump_reg(jump_reg), .branch(branch),
        .pc_write(dout[0][3]), .if_id_write(dout[0][2]), .control(dout[0][1]),
        .if_id_flush(dout[0][0]), .stall_count(scnt[0]), .error(derr[0]));

    hazard_scoreboard #(.FWD_SLACK(1), .FLUSH_DEPTH(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_reg_write(id_reg_write),
        .id_rd(id_rd), .id_latency(id_latency), .jump(jump), .jump_reg(jump_reg), .branch(branch),
        .pc_write(dout[1][3]), .if_id_write(dout[1][2]), .control(dout[1][1]),
        .if_id_flush(dout[1][0]), .stall_count(scnt[1]), .error(derr[1]));

    hazard_scoreboard #(.FWD_SLACK(2), .FLUSH_DEPTH(3)) dut2 (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_reg_write(id_reg_write),
        .id_rd(id_rd), .id_latency(id_latency), .jump(jump), .jump_reg(jump_reg), .branch(branch),
        .pc_write(dout[2][3]), .if_id_write(dout[2][2]), .control(dout[2][1]),
        .if_id_flush(dout[2][0]), .stall_count(scnt[2]), .error(derr[2]));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic int slack_of(int k);
        return (k == 0) ? 0 : (k == 1) ? 1 : 2;
    endfunction

    function automatic int depth_of(int k);
        return (k == 2) ? 3 : 1;
    endfunction

    // Cycles still outstanding before register r's pending write lands, as seen in the current cycle.
    function automatic longint rem(int k, int r);
        if (r == 0) return 0;
        return (ready_at[k][r] > ncyc) ? ready_at[k][r] - ncyc : 0;
    endfunction

    function automatic void model_clear(int k);
        for (int r = 0; r < 32; r++) ready_at[k][r] = 0;
        flush_left[k] = 0;
        scm[k]        = 0;
        errm[k]       = 1'b0;
        runm[k]       = 0;
    endfunction

    function automatic exp_t model_step();
        exp_t e;
        e = '0;
        for (int k = 0; k < 3; k++) begin
            bit st, iss, hz;
            st  = 1'b0;
            iss = 1'b0;
            if (!rst_n) begin
                e.outv[k] = 4'b0001;
                e.sc[k]   = 32'd0;
                e.err[k]  = 1'b0;
                model_clear(k);
            end else begin
                e.sc[k]  = 32'(scm[k]);
                e.err[k] = errm[k];
                if (flush_left[k] > 0) begin
                    e.outv[k] = 4'b1011;
                    flush_left[k]--;
                end else if (id_valid) begin
                    hz = (id_uses_rs && rem(k, id_rs) > slack_of(k)) ||
                         (id_uses_rt && rem(k, id_rt) > slack_of(k)) ||
                         (jump_reg && rem(k, id_rs) != 0) ||
                         (branch && (rem(k, id_rs) != 0 || rem(k, id_rt) != 0));
                    if (hz) begin
                        e.outv[k] = 4'b0000;
                        st = 1'b1;
                    end else begin
                        iss = 1'b1;
                        if (jump || jump_reg || branch) begin
                            e.outv[k]     = 4'b1011;
                            flush_left[k] = depth_of(k) - 1;
                        end else begin
                            e.outv[k] = 4'b1110;
                        end
                    end
                end else begin
                    e.outv[k] = 4'b1110;
                end
                if (iss && id_reg_write && id_rd != 0 && id_latency != 0)
                    ready_at[k][id_rd] = ncyc + 1 + ((id_latency > MAXL) ? MAXL : id_latency);
                if (st) begin
                    if (scm[k] < 64'hFFFF_FFFF) scm[k]++;
                    runm[k]++;
                    if (runm[k] > MAXL + 1) errm[k] = 1'b1;
                end else begin
                    runm[k] = 0;
                end
            end
        end
        ncyc++;
        return e;
    endfunction

    task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[dut%0d] at cycle %0d: got %0h expected %0h", nm, k, ncyc, act, exp);
        end
    endtask

    task automatic cyc(input logic rst_v, input logic v, input logic [4:0] rs, input logic [4:0] rt,
                       input logic urs, input logic urt, input logic rw, input logic [4:0] rd,
                       input logic [2:0] lat, input logic j, input logic jr, input logic br);
        @(posedge clk);
        #1;
        rst_n        = rst_v;
        id_valid     = v;
        id_rs        = rs;
        id_rt        = rt;
        id_uses_rs   = urs;
        id_uses_rt   = urt;
        id_reg_write = rw;
        id_rd        = rd;
        id_latency   = lat;
        jump         = j;
        jump_reg     = jr;
        branch       = br;
        expq.push_back(model_step());
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    always @(negedge clk) begin
        if (expq.size() > 0) begin
            me = expq.pop_front();
            for (int k = 0; k < 3; k++) begin
                chk("outputs", k, {28'd0, dout[k]}, {28'd0, me.outv[k]});
                chk("stall_count", k, scnt[k], me.sc[k]);
                chk("error", k, {31'd0, derr[k]}, {31'd0, me.err[k]});
            end
        end
    end

    initial begin
        rst_n = 1'b0; id_valid = 0; id_rs = 0; id_rt = 0; id_uses_rs = 0; id_uses_rt = 0;
        id_reg_write = 0; id_rd = 0; id_latency = 0; jump = 0; jump_reg = 0; branch = 0;
        for (int k = 0; k < 3; k++) model_clear(k);

        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(3);
        @(negedge clk);
        chk("sc_after_reset", 0, scnt[0], 32'd0);
        chk("normal_after_reset", 0, {28'd0, dout[0]}, 32'h0000_000E);

        // Rd=5 L=3 producer followed by a reader of r5 held in ID.
        cyc(1, 1, 0, 0, 0, 0, 1, 5, 3, 0, 0, 0);
        for (int i = 0; i < 4; i++) cyc(1, 1, 5, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        idle(1);
        @(negedge clk);
        chk("sc_raw_slack0", 0, scnt[0], 32'd3);
        chk("sc_raw_slack1", 1, scnt[1], 32'd2);
        chk("sc_raw_slack2", 2, scnt[2], 32'd1);

        // Writes to r0 never create hazards.
        cyc(1, 1, 0, 0, 0, 0, 1, 0, 7, 0, 0, 0);
        cyc(1, 1, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0);

        // JumpReg on a pending r8, then younger instructions during the flush window.
        cyc(1, 1, 0, 0, 0, 0, 1, 8, 2, 0, 0, 0);
        for (int i = 0; i < 3; i++) cyc(1, 1, 8, 0, 1, 0, 0, 0, 0, 0, 1, 0);
        cyc(1, 1, 0, 0, 0, 0, 1, 9, 5, 0, 0, 0);
        cyc(1, 1, 0, 0, 0, 0, 1, 9, 5, 0, 0, 0);
        for (int i = 0; i < 6; i++) cyc(1, 1, 9, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        idle(1);

        // WAW: the younger short-latency write replaces the long one.
        cyc(1, 1, 0, 0, 0, 0, 1, 4, 7, 0, 0, 0);
        cyc(1, 1, 0, 0, 0, 0, 1, 4, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) cyc(1, 1, 4, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("waw_error", 0, {31'd0, derr[0]}, 32'd0);

        // Reset pulsed while dut2 is mid-redirect, with a pending write outstanding.
        cyc(1, 1, 0, 0, 0, 0, 1, 6, 7, 1, 0, 0);
        cyc(0, 1, 6, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 1, 6, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 1, 6, 6, 1, 1, 0, 0, 0, 0, 0, 1);

        for (int i = 0; i < 3000; i++) begin
            logic [4:0] rs, rt, rd;
            logic [2:0] lat;
            int         ctl;
            rs  = ($urandom_range(0, 9) < 8) ? 5'($urandom_range(0, 7)) : 5'($urandom);
            rt  = 5'($urandom_range(0, 7));
            rd  = ($urandom_range(0, 9) < 8) ? 5'($urandom_range(0, 7)) : 5'($urandom);
            lat = 3'($urandom_range(1, 7));
            ctl = $urandom_range(0, 19);
            cyc(($urandom_range(0, 99) != 0), ($urandom_range(0, 9) != 0), rs, rt,
                1'($urandom), 1'($urandom), 1'($urandom), rd, lat,
                ctl == 0, ctl == 1, ctl == 2);
        end

        idle(2);
        @(negedge clk);
        @(negedge clk);
        chk("queue_drained", 0, 32'(expq.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
